target_judge: RTL and testbench

TARGET_JUDGE -- requirements
Module: target_judge

---
 rtl/game_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 43 ++++
 rtl/target_judge.sv | 139 +++++++++++++
 tb/tb_target_judge.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the target/judge game logic.
// Holds the FSM state encoding, LFSR definition and score limit.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRelease,
    StShow,
    StDone
  } game_state_e;

  localparam int unsigned NUM_BTN   = 8;
  localparam int unsigned SCORE_W   = 10;
  localparam int unsigned SCORE_MAX = 999;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [NUM_BTN-1:0] onehot8(input logic [2:0] idx);
    return NUM_BTN'(1) << idx;
  endfunction

  // Avoid showing the same target twice in a row.
  function automatic logic [2:0] pick_target(input logic [2:0] raw, input logic [2:0] prev);
    return (raw == prev) ? raw + 3'd1 : raw;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit push-button conditioner: 2-flop synchroniser followed by a
// debouncer that accepts a new level after DEBOUNCE_CYCLES stable cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_level_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      // Any cycle agreeing with the accepted level restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign btn_level_o = level_q;

endmodule

// File: rtl/target_judge.sv
// Reaction game judge: lights a random target LED, judges debounced button
// presses or a timeout as hit/miss, and keeps a saturating score.
module target_judge
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TICK_CYCLES     = 5000,
  parameter int unsigned TIMEOUT_TICKS   = 10000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               game_over,
  output logic [NUM_BTN-1:0] led,
  output logic               miss,
  output logic               hit,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned TickW = $clog2(TICK_CYCLES + 1);
  localparam int unsigned ToutW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_CYCLES - 1);
  localparam logic [ToutW-1:0] ToutLast  = ToutW'(TIMEOUT_TICKS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = SCORE_W'(SCORE_MAX);

  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_level_q;
  logic [NUM_BTN-1:0] press;
  logic [15:0]        lfsr_q;
  game_state_e        state_q;
  logic [2:0]         target_q;
  logic [2:0]         next_target;
  logic [TickW-1:0]   cycle_cnt_q;
  logic [ToutW-1:0]   tick_cnt_q;
  logic               tick_strobe;
  logic               timeout;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clock      (clock),
      .reset      (reset),
      .btn_raw_i  (btn[i]),
      .btn_level_o(btn_level[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_level_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      btn_level_q <= btn_level;
      lfsr_q      <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    press       = btn_level & ~btn_level_q;
    next_target = pick_target(lfsr_q[2:0], target_q);
    tick_strobe = (cycle_cnt_q == TickLast);
    timeout     = tick_strobe && (tick_cnt_q == ToutLast);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      led         <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      score       <= '0;
      target_q    <= 3'd0;
      cycle_cnt_q <= '0;
      tick_cnt_q  <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      // game_over overrides any judgement pending in the same cycle.
      if (game_over) begin
        state_q <= StDone;
        led     <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            led     <= '0;
            state_q <= StRelease;
          end
          StRelease: begin
            led <= '0;
            if (btn_level == '0) begin
              target_q    <= next_target;
              led         <= onehot8(next_target);
              cycle_cnt_q <= '0;
              tick_cnt_q  <= '0;
              state_q     <= StShow;
            end
          end
          StShow: begin
            cycle_cnt_q <= tick_strobe ? '0 : cycle_cnt_q + TickW'(1);
            if (tick_strobe) begin
              tick_cnt_q <= tick_cnt_q + ToutW'(1);
            end
            // A press in the timeout cycle is judged as a press.
            if (press != '0) begin
              if (press == onehot8(target_q)) begin
                hit <= 1'b1;
                if (score != ScoreMax) begin
                  score <= score + SCORE_W'(1);
                end
              end else begin
                miss <= 1'b1;
              end
              led     <= '0;
              state_q <= StRelease;
            end else if (timeout) begin
              miss    <= 1'b1;
              led     <= '0;
              state_q <= StRelease;
            end
          end
          StDone: begin
            led <= '0;
          end
          default: begin
            led     <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_hit_miss_excl : assert property (@(posedge clock) disable iff (!reset) !(hit && miss));
  a_led_onehot0   : assert property (@(posedge clock) disable iff (!reset) $onehot0(led));
`endif

endmodule

// File: tb/tb_target_judge.sv
// Randomised self-checking bench for target_judge with a behavioural model
// of the target sequence, score and judgement timing.
module tb_target_judge;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 10;
  localparam int unsigned TOUT = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] btn = 8'h00;
  logic       game_over = 1'b0;
  logic [7:0] led;
  logic       miss;
  logic       hit;
  logic [9:0] score;

  int checks = 0;
  int errors = 0;

  // Reference state: LFSR value the DUT used at the last edge, score, current target.
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] lfsr_used = 16'hACE1;
  int          m_score = 0;
  int          m_prev = 0;

  always #5 clock = ~clock;

  target_judge #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK),
    .TIMEOUT_TICKS  (TOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn      (btn),
    .game_over(game_over),
    .led      (led),
    .miss     (miss),
    .hit      (hit),
    .score    (score)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  always @(posedge clock) begin
    lfsr_used <= m_lfsr;
    if (!reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= ref_step(m_lfsr);
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic wait_target(input string name, input int limit);
    bit         seen = 1'b0;
    int         raw;
    int         exp_t;
    logic [7:0] exp_led;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (led !== 8'h00) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_target: led=%b after %0d cycles, expected a one-hot target", name, led,
               limit);
    end else begin
      raw     = int'(lfsr_used[2:0]);
      exp_t   = (raw == m_prev) ? (raw + 1) % 8 : raw;
      exp_led = 8'(1 << exp_t);
      if (led !== exp_led) begin
        errors++;
        $display("FAIL %s_target: led=%b expected %b", name, led, exp_led);
      end
      m_prev = exp_t;
    end
  endtask

  task automatic judge_press(input logic [7:0] mask, input bit bounce, input string name);
    int         hits = 0;
    int         misses = 0;
    int         both = 0;
    int         lit_after = 0;
    bit         judged = 1'b0;
    bit         correct;
    logic [7:0] tgt;
    tgt     = 8'(1 << m_prev);
    correct = (mask == tgt);
    if (bounce) begin
      for (int i = 0; i < 3; i++) begin
        btn = ($urandom_range(0, 1) == 1) ? mask : 8'h00;
        cyc();
      end
    end
    btn = mask;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (judged && led !== 8'h00) lit_after++;
      if (hit === 1'b1) hits++;
      if (miss === 1'b1) misses++;
      if (hit === 1'b1 && miss === 1'b1) both++;
      if (hit === 1'b1 || miss === 1'b1) judged = 1'b1;
    end
    if (correct && m_score < 999) m_score++;
    checks++;
    if (hits != (correct ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_hit: %0d hit pulses, expected %0d (mask=%b tgt=%b)", name, hits,
               correct ? 1 : 0, mask, tgt);
    end
    checks++;
    if (misses != (correct ? 0 : 1)) begin
      errors++;
      $display("FAIL %s_miss: %0d miss pulses, expected %0d (mask=%b tgt=%b)", name, misses,
               correct ? 0 : 1, mask, tgt);
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL %s_excl: hit and miss together in %0d cycles, expected 0", name, both);
    end
    checks++;
    if (lit_after != 0 || led !== 8'h00) begin
      errors++;
      $display("FAIL %s_led_held: led lit %0d cycles (now %b) while held, expected 0", name,
               lit_after, led);
    end
    checks++;
    if (score !== 10'(m_score)) begin
      errors++;
      $display("FAIL %s_score: score=%0d expected %0d", name, score, m_score);
    end
    btn = 8'h00;
    wait_target(name, 20);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    checks++;
    if (led !== 8'h00 || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: led=%b hit=%b miss=%b expected 0/0/0", led, hit, miss);
    end
    checks++;
    if (score !== 10'd0) begin
      errors++;
      $display("FAIL reset_score: score=%0d expected 0", score);
    end
    reset   = 1'b1;
    m_score = 0;
    m_prev  = 0;
    wait_target("reset", 3);
    checks++;
    if (score !== 10'd0) begin
      errors++;
      $display("FAIL reset_score_show: score=%0d expected 0", score);
    end
  endtask

  task automatic test_timeout();
    int         n = 0;
    int         hits = 0;
    bit         seen = 1'b0;
    logic [7:0] old;
    old = 8'(1 << m_prev);
    for (int i = 0; i < 60; i++) begin
      cyc();
      n++;
      if (hit === 1'b1) hits++;
      if (miss === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != int'(TICK * TOUT)) begin
      errors++;
      $display("FAIL timeout_time: miss seen=%0d after %0d cycles, expected after %0d", seen, n,
               TICK * TOUT);
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL timeout_hit: %0d hit pulses, expected 0", hits);
    end
    wait_target("timeout", 20);
    checks++;
    if (led === old) begin
      errors++;
      $display("FAIL timeout_new_target: led=%b same as previous %b", led, old);
    end
  endtask

  task automatic test_short_glitch();
    int         pulses = 0;
    logic [7:0] tgt;
    tgt = 8'(1 << m_prev);
    btn = tgt;
    repeat (DEB - 1) cyc();
    btn = 8'h00;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (hit === 1'b1 || miss === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_pulses: %0d pulses from a %0d-cycle glitch, expected 0", pulses,
               DEB - 1);
    end
    checks++;
    if (led !== tgt) begin
      errors++;
      $display("FAIL glitch_led: led=%b expected %b", led, tgt);
    end
  endtask

  task automatic test_random_presses();
    logic [7:0] tgt;
    logic [7:0] mask;
    for (int k = 0; k < 10; k++) begin
      tgt = 8'(1 << m_prev);
      case ($urandom_range(0, 2))
        0: mask = tgt;
        1: mask = 8'(1 << ((m_prev + int'($urandom_range(1, 7))) % 8));
        default: mask = tgt | 8'(1 << ((m_prev + int'($urandom_range(1, 7))) % 8));
      endcase
      judge_press(mask, bit'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_show();
    reset = 1'b0;
    cyc();
    checks++;
    if (led !== 8'h00 || hit !== 1'b0 || miss !== 1'b0 || score !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset: led=%b hit=%b miss=%b score=%0d expected all 0", led, hit, miss,
               score);
    end
    reset   = 1'b1;
    m_score = 0;
    m_prev  = 0;
    wait_target("mid_reset", 3);
  endtask

  task automatic test_saturate();
    while (m_score < 999 && errors < 20) judge_press(8'(1 << m_prev), 1'b0, "sat");
    judge_press(8'(1 << m_prev), 1'b0, "sat_max");
    checks++;
    if (score !== 10'd999) begin
      errors++;
      $display("FAIL sat_final: score=%0d expected 999", score);
    end
  endtask

  task automatic test_game_over();
    int         pulses = 0;
    int         lit = 0;
    int         moved = 0;
    logic [7:0] tgt;
    tgt = 8'(1 << m_prev);
    btn = tgt;
    // Two sync stages plus DEB stable cycles put the press edge here.
    repeat (2 + DEB) cyc();
    game_over = 1'b1;
    cyc();
    checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL gameover_pulse: hit=%b miss=%b expected 0/0", hit, miss);
    end
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL gameover_led: led=%b expected 0", led);
    end
    game_over = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) btn = 8'($urandom_range(0, 255));
      cyc();
      if (hit === 1'b1 || miss === 1'b1) pulses++;
      if (led !== 8'h00) lit++;
      if (score !== 10'(m_score)) moved++;
    end
    checks++;
    if (pulses != 0 || lit != 0) begin
      errors++;
      $display("FAIL done_stuck: %0d pulses %0d lit cycles in DONE, expected 0/0", pulses, lit);
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL done_score: score differed from %0d in %0d cycles, expected 0", m_score,
               moved);
    end
    btn   = 8'h00;
    reset = 1'b0;
    repeat (2) cyc();
    checks++;
    if (score !== 10'd0 || led !== 8'h00) begin
      errors++;
      $display("FAIL done_reset: score=%0d led=%b expected 0/0", score, led);
    end
    reset   = 1'b1;
    m_score = 0;
    m_prev  = 0;
    wait_target("after_done", 3);
  endtask

  initial begin
    test_reset();
    test_timeout();
    judge_press(8'(1 << m_prev), 1'b1, "correct");
    judge_press(8'(1 << ((m_prev + 3) % 8)), 1'b1, "wrong");
    judge_press(8'(1 << m_prev) | 8'(1 << ((m_prev + 5) % 8)), 1'b1, "combo");
    test_short_glitch();
    judge_press(8'(1 << m_prev), 1'b0, "after_glitch");
    test_random_presses();
    test_reset_mid_show();
    test_saturate();
    test_game_over();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
